agc_gain_compensator: RTL and testbench

- Sits downstream of auto_gain_control.
- Takes raw 12-bit ADC samples together with the relay gain state (relay_ctrl, stable) and produces input-referred amplitude samples by dividing out the active front-end gain (3, 6.5, 13.5 or 29.25x).
- Drops samples while relays switch or settle, tags each output with the gain it was scaled by, and flags near-full-scale inputs.
- Feeds the measurement and display path.

---
 rtl/agc_pkg.sv | 28 ++
 rtl/agc_scale_pipe.sv | 86 ++++++++
 rtl/agc_gain_compensator.sv | 110 +++++++++++
 tb/tb_agc_gain_compensator.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/agc_pkg.sv
// Shared AGC definitions: relay gain encoding, FSM states and the
// gain-compensation coefficient table used by the scaling datapath.
package agc_pkg;

  localparam int DATA_W    = 12;
  localparam int COEF_W    = 19;
  localparam int PROD_W    = DATA_W + COEF_W;
  localparam int COEF_FRAC = 4;

  typedef enum logic [1:0] {
    G3     = 2'b00,
    G6P5   = 2'b01,
    G13P5  = 2'b10,
    G29P25 = 2'b11
  } gain_sel_t;

  typedef enum logic [1:0] {
    WAIT_STABLE = 2'b00,
    BLANK       = 2'b01,
    RUN         = 2'b10
  } agc_state_t;

  // round(2^(16+COEF_FRAC) / gain) for 3, 6.5, 13.5 and 29.25x
  localparam logic [COEF_W-1:0] COEF [4] = '{
    19'd349525, 19'd161319, 19'd77672, 19'd35849
  };

endpackage

// File: rtl/agc_scale_pipe.sv
// Three-stage multiply / round / saturate datapath that divides out the
// front-end gain; only the valid chain and the outputs are reset.
module agc_scale_pipe
  import agc_pkg::*;
#(
  parameter int OUT_W   = 16,
  parameter int CLIP_TH = 4000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [COEF_W-1:0]   in_coef,
  input  logic [1:0]          in_gain,
  output logic                out_valid,
  output logic [OUT_W-1:0]    out_data,
  output logic [1:0]          out_gain,
  output logic                out_clip
);

  localparam logic [DATA_W-1:0] CLIP_Q  = DATA_W'(CLIP_TH);
  localparam logic [31:0]       SAT_MAX = 32'((64'd1 << OUT_W) - 64'd1);

  logic                vld_p0, vld_p1;
  logic [DATA_W-1:0]   data_p0;
  logic [COEF_W-1:0]   coef_p0;
  logic [1:0]          gain_p0, gain_p1;
  logic                clip_p0, clip_p1;
  logic [PROD_W-1:0]   prod_p1;

  function automatic logic [OUT_W-1:0] round_sat(input logic [PROD_W-1:0] p);
    logic [PROD_W:0]    r;
    logic [PROD_W-16:0] q;
    r = {1'b0, p} + (PROD_W+1)'(32'd32768);
    q = r[PROD_W:16];
    if (32'(q) > SAT_MAX) return '1;
    return OUT_W'(q);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= in_valid;
      vld_p1 <= vld_p0;
    end
  end

  // p0: capture sample, coefficient, gain tag and clip flag
  always_ff @(posedge clk) begin
    if (in_valid) begin
      data_p0 <= in_data;
      coef_p0 <= in_coef;
      gain_p0 <= in_gain;
      clip_p0 <= (in_data >= CLIP_Q);
    end
  end

  // p1: full-precision product
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      prod_p1 <= PROD_W'(data_p0) * PROD_W'(coef_p0);
      gain_p1 <= gain_p0;
      clip_p1 <= clip_p0;
    end
  end

  // p2: round, saturate and hold outputs between samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_gain  <= 2'b00;
      out_clip  <= 1'b0;
    end else begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        out_data <= round_sat(prod_p1);
        out_gain <= gain_p1;
        out_clip <= clip_p1;
      end
    end
  end

endmodule

// File: rtl/agc_gain_compensator.sv
// Converts raw ADC codes to input-referred amplitude, discarding samples
// while the relays switch or settle after the AGC changes gain.
module agc_gain_compensator
  import agc_pkg::*;
#(
  parameter int FRAC          = 4,
  parameter int OUT_W         = 16,
  parameter int BLANK_SAMPLES = 4,
  parameter int CLIP_TH       = 4000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adc_valid,
  input  logic [11:0]      adc_data,
  input  logic [1:0]       relay_ctrl,
  input  logic             stable,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_gain,
  output logic             out_clip,
  output logic             blank
);

  localparam int CNT_W = (BLANK_SAMPLES < 1) ? 1 : $clog2(BLANK_SAMPLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLANK_SAMPLES - 1);

  if (FRAC != COEF_FRAC) begin : g_frac_chk
    $error("agc_gain_compensator: coefficient table is built for FRAC=4");
  end

  agc_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]      relay_q;
  logic            gain_chg;
  logic            accept;
  gain_sel_t       relay_sel;

  assign gain_chg  = (relay_ctrl != relay_q);
  assign relay_sel = gain_sel_t'(relay_ctrl);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= WAIT_STABLE;
      cnt     <= '0;
      relay_q <= 2'b00;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      relay_q <= relay_ctrl;
    end
  end

  // Losing stable dominates a gain change; samples coinciding with either are ignored.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      WAIT_STABLE: begin
        cnt_nxt = '0;
        if (stable && !gain_chg) state_nxt = BLANK;
      end
      BLANK: begin
        if (!stable) begin
          state_nxt = WAIT_STABLE;
        end else if (gain_chg) begin
          cnt_nxt = '0;
        end else if (BLANK_SAMPLES == 0) begin
          state_nxt = RUN;
        end else if (adc_valid) begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == LAST_CNT) state_nxt = RUN;
        end
      end
      RUN: begin
        if (!stable) begin
          state_nxt = WAIT_STABLE;
        end else if (gain_chg) begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = WAIT_STABLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    blank  = (state != RUN);
    accept = (state == RUN) && adc_valid && stable && !gain_chg;
  end

  agc_scale_pipe #(
    .OUT_W   (OUT_W),
    .CLIP_TH (CLIP_TH)
  ) u_scale_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept),
    .in_data   (adc_data),
    .in_coef   (COEF[relay_sel]),
    .in_gain   (relay_ctrl),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_gain  (out_gain),
    .out_clip  (out_clip)
  );

endmodule

// File: tb/tb_agc_gain_compensator.sv
// Scoreboard bench for agc_gain_compensator: expected outputs are queued
// when a sample is driven and matched against the DUT output strobe.
module tb_agc_gain_compensator;

  localparam int GAP = 100;

  logic        clk;
  logic        rst;
  logic        adc_valid;
  logic [11:0] adc_data;
  logic [1:0]  relay_ctrl;
  logic        stable;
  logic        out_valid;
  logic [15:0] out_data;
  logic [1:0]  out_gain;
  logic        out_clip;
  logic        blank;

  typedef struct {
    int          due;
    logic [15:0] data;
    logic [1:0]  gain;
    logic        clip;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  agc_gain_compensator #(
    .FRAC          (4),
    .OUT_W         (16),
    .BLANK_SAMPLES (4),
    .CLIP_TH       (4000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .adc_valid  (adc_valid),
    .adc_data   (adc_data),
    .relay_ctrl (relay_ctrl),
    .stable     (stable),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_gain   (out_gain),
    .out_clip   (out_clip),
    .blank      (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [15:0] d, input logic c);
    exp_t e;
    e.due  = cyc + 3;
    e.data = d;
    e.gain = relay_ctrl;
    e.clip = c;
    sb.push_back(e);
  endtask

  // One isolated sample; exp_blank is the blank level seen while it is driven.
  task automatic send(input logic [11:0] d, input bit emit, input logic [15:0] exp_d,
                      input logic exp_c, input int exp_blank);
    @(posedge clk); #1;
    chk("blank_at_drive", blank, exp_blank);
    adc_valid = 1'b1;
    adc_data  = d;
    if (emit) push_exp(exp_d, exp_c);
    @(posedge clk); #1;
    adc_valid = 1'b0;
    repeat (GAP) @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", out_valid, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("latency", cyc, e.due);
        chk("out_data", out_data, e.data);
        chk("out_gain", out_gain, e.gain);
        chk("out_clip", out_clip, e.clip);
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      chk("missing_out_valid", out_valid, 1);
      void'(sb.pop_front());
    end
  end

  initial begin
    #1ms;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: bench did not complete within time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    rst        = 1'b1;
    adc_valid  = 1'b0;
    adc_data   = 12'd0;
    relay_ctrl = 2'b00;
    stable     = 1'b0;
    #23;
    chk("rst_blank", blank, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_gain", out_gain, 0);
    chk("rst_out_clip", out_clip, 0);

    @(posedge clk); #1;
    rst    = 1'b0;
    stable = 1'b1;
    repeat (5) @(posedge clk);

    // Initial settle: four dropped, fifth emitted at 3x
    for (int i = 0; i < 4; i++) send(12'd1843, 0, 16'd0, 1'b0, 1);
    send(12'd1843, 1, 16'd9829, 1'b0, 0);

    // Switch to 29.25x, full-scale sample clips
    relay_ctrl = 2'b11;
    for (int i = 0; i < 4; i++) send(12'd4095, 0, 16'd0, 1'b0, 1);
    send(12'd4095, 1, 16'd2240, 1'b1, 0);

    // Switch to 13.5x
    relay_ctrl = 2'b10;
    for (int i = 0; i < 4; i++) send(12'd2048, 0, 16'd0, 1'b0, 1);
    send(12'd2048, 1, 16'd2427, 1'b0, 0);

    // Relays unsettled: nothing emitted while stable is low
    stable = 1'b0;
    for (int i = 0; i < 10; i++) send(12'd2048, 0, 16'd0, 1'b0, 1);
    stable = 1'b1;
    for (int i = 0; i < 4; i++) send(12'd2048, 0, 16'd0, 1'b0, 1);
    send(12'd2048, 1, 16'd2427, 1'b0, 0);

    // Gain change coincident with a sample: that sample is neither emitted nor counted
    @(posedge clk); #1;
    chk("blank_before_chg", blank, 0);
    relay_ctrl = 2'b00;
    adc_valid  = 1'b1;
    adc_data   = 12'd1843;
    @(posedge clk); #1;
    adc_valid = 1'b0;
    repeat (GAP) @(posedge clk);
    for (int i = 0; i < 4; i++) send(12'd1843, 0, 16'd0, 1'b0, 1);
    send(12'd1843, 1, 16'd9829, 1'b0, 0);

    // Back-to-back samples at 3x
    @(posedge clk); #1;
    adc_valid = 1'b1;
    adc_data  = 12'd100;
    push_exp(16'd533, 1'b0);
    @(posedge clk); #1;
    adc_data = 12'd200;
    push_exp(16'd1067, 1'b0);
    @(posedge clk); #1;
    adc_data = 12'd300;
    push_exp(16'd1600, 1'b0);
    @(posedge clk); #1;
    adc_valid = 1'b0;
    repeat (GAP) @(posedge clk);
    chk("hold_out_data", out_data, 1600);

    // Reset with a sample in flight
    @(posedge clk); #1;
    adc_valid = 1'b1;
    adc_data  = 12'd1843;
    @(posedge clk); #1;
    adc_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_blank", blank, 1);
    chk("midrst_out_valid", out_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_out_data", out_data, 0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    for (int i = 0; i < 4; i++) send(12'd1843, 0, 16'd0, 1'b0, 1);
    send(12'd1843, 1, 16'd9829, 1'b0, 0);

    repeat (20) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
